// File: rtl/move_cmd_gen_pkg.sv
// Shared definitions for the ship movement command generator: state
// encoding, direction constants and the default timing constants that the
// ship movement FSM benches also use.
package move_cmd_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } MoveState_t;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  localparam int DEF_DEB_CYCLES   = 4;
  localparam int DEF_REPEAT_DELAY = 8;
  localparam int DEF_REPEAT_RATE  = 4;
  localparam int DEF_CNT_W        = 8;

endpackage

// File: rtl/move_cmd_gen_if.sv
// Button/command bundle between the player's push-buttons and the ship
// movement FSM. Signal prefixes are from the generator's point of view.
interface move_cmd_gen_if;

  logic i_btnL;
  logic i_btnR;
  logic i_en;
  logic o_left;
  logic o_right;
  logic o_busy;

  modport slave (
    input  i_btnL,
    input  i_btnR,
    input  i_en,
    output o_left,
    output o_right,
    output o_busy
  );

  modport master (
    output i_btnL,
    output i_btnR,
    output i_en,
    input  o_left,
    input  o_right,
    input  o_busy
  );

endinterface

// File: rtl/move_cmd_gen_debounce_sync.sv
// Two-flop synchroniser followed by a debouncer for one raw push-button.
// The debounced level only changes once DEB_CYCLES consecutive synchronised
// samples disagree with it; any agreeing sample restarts the count.
module move_cmd_gen_debounce_sync
  import move_cmd_gen_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  // Synchronise the raw button, then count disagreeing samples up to DEB_LAST.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DEB_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/move_cmd_gen.sv
// Turns the raw LEFT/RIGHT push-buttons of one player into clean single-cycle
// move commands: one pulse per press, then hold-to-auto-repeat. Pressing
// both buttons locks out movement until both are released again.
module move_cmd_gen
  import move_cmd_gen_pkg::*;
#(
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic          i_clk,
  input  logic          i_rst,
  move_cmd_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic             w_dl;
  logic             w_dr;
  logic             r_dl;
  logic             r_dr;
  MoveState_t       r_state;
  MoveState_t       w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_nextCnt;
  logic [CNT_W-1:0] w_last;
  logic             r_dir;
  logic             w_nextDir;
  logic             w_active;
  logic             w_other;
  logic             w_pulseL;
  logic             w_pulseR;
  logic             r_left;
  logic             r_right;
  logic             r_busy;

  move_cmd_gen_debounce_sync #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_debL (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_raw   (bus.i_btnL),
    .o_level (w_dl)
  );

  move_cmd_gen_debounce_sync #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_debR (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_raw   (bus.i_btnR),
    .o_level (w_dr)
  );

  assign w_active = (r_dir == DIR_L) ? r_dl : r_dr;
  assign w_other  = (r_dir == DIR_L) ? r_dr : r_dl;
  assign w_last   = (r_state == DELAY) ? DELAY_LAST : RATE_LAST;

  // Next state, repeat counter, latched direction and pulse requests.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextDir   = r_dir;
    w_pulseL    = 1'b0;
    w_pulseR    = 1'b0;
    if (!bus.i_en) begin
      w_nextState = IDLE;
      w_nextCnt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_nextCnt = '0;
          if (r_dl ^ r_dr) begin
            w_nextDir   = r_dr ? DIR_R : DIR_L;
            w_pulseL    = !r_dr;
            w_pulseR    = r_dr;
            w_nextState = DELAY;
          end else if (r_dl & r_dr) begin
            w_nextState = LOCK;
          end
        end
        DELAY, REPEAT: begin
          if (!w_active) begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
          end else if (w_other) begin
            w_nextState = LOCK;
            w_nextCnt   = '0;
          end else if (r_cnt == w_last) begin
            w_pulseL    = (r_dir == DIR_L);
            w_pulseR    = (r_dir == DIR_R);
            w_nextCnt   = '0;
            w_nextState = REPEAT;
          end else begin
            w_nextCnt = r_cnt + CNT_W'(1);
          end
        end
        LOCK: begin
          w_nextCnt = '0;
          if (!r_dl && !r_dr) begin
            w_nextState = IDLE;
          end
        end
        default: begin
          w_nextState = IDLE;
          w_nextCnt   = '0;
        end
      endcase
    end
  end

  // Register debounced levels, FSM state and all outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dl    <= 1'b0;
      r_dr    <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dir   <= DIR_L;
      r_left  <= 1'b0;
      r_right <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_dl    <= w_dl;
      r_dr    <= w_dr;
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_dir   <= w_nextDir;
      r_left  <= w_pulseL;
      r_right <= w_pulseR;
      r_busy  <= (w_nextState != IDLE);
    end
  end

  assign bus.o_left  = r_left;
  assign bus.o_right = r_right;
  assign bus.o_busy  = r_busy;

endmodule
